vsbuf_ctrl: RTL

VSBUF_CTRL -- requirements
Module: vsbuf_ctrl

---
 rtl/vsbuf_ctrl.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/vsbuf_ctrl.sv
// Frame-buffer ring controller: hands the writer and the reader buffer indices,
// either at a fixed frame lag (MODE 0) or as latest-complete with collision avoidance (MODE 1).
module vsbuf_ctrl #(
  parameter int BUF_LENTH = 3,
  parameter int BUF_DELAY = 1,
  parameter int MODE      = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_frame_start,
  input  logic        wr_frame_done,
  input  logic        rd_frame_start,
  output logic [7:0]  wr_bufn,
  output logic [7:0]  rd_bufn,
  output logic        rd_valid,
  output logic [15:0] drop_cnt,
  output logic [15:0] rep_cnt
);

  localparam logic [0:0] ST_IDLE    = 1'b0;
  localparam logic [0:0] ST_WRITING = 1'b1;

  localparam logic [7:0] LEN    = 8'(BUF_LENTH);
  localparam logic [7:0] RD_LAG = 8'(BUF_LENTH - 1 - BUF_DELAY);
  localparam logic [7:0] RD_RST = (MODE == 0) ? 8'((BUF_LENTH - 1 - BUF_DELAY) % BUF_LENTH)
                                              : 8'(BUF_LENTH - 1);

  // Operands are always < LEN and k < LEN, so one conditional subtract wraps correctly.
  function automatic logic [7:0] wrap_add(input logic [7:0] a, input logic [7:0] k);
    logic [7:0] s;
    s = a + k;
    if (s >= LEN) begin
      s = s - LEN;
    end else begin
      s = s;
    end
    return s;
  endfunction

  function automatic logic [15:0] sat_add(input logic [15:0] c, input logic [1:0] inc);
    logic [16:0] s;
    s = {1'b0, c} + {15'd0, inc};
    if (s[16]) begin
      return 16'hFFFF;
    end else begin
      return s[15:0];
    end
  endfunction

  logic [0:0]  state_q, state_d;
  logic [7:0]  wr_bufn_q, wr_bufn_d;
  logic [7:0]  rd_bufn_q, rd_bufn_d;
  logic [7:0]  last_done_q, last_done_d;
  logic        done_valid_q, done_valid_d;
  logic        rd_valid_q, rd_valid_d;
  logic        handed_q, handed_d;
  logic [15:0] drop_cnt_q, drop_cnt_d;
  logic [15:0] rep_cnt_q, rep_cnt_d;

  logic        done_acc;
  logic [7:0]  cand;
  logic        drop_unread;
  logic        drop_block;
  logic        rep_inc;

  // Next-state logic for the writer FSM, buffer indices and event counters.
  always_comb begin
    state_d      = state_q;
    wr_bufn_d    = wr_bufn_q;
    rd_bufn_d    = rd_bufn_q;
    last_done_d  = last_done_q;
    done_valid_d = done_valid_q;
    rd_valid_d   = rd_valid_q;
    handed_d     = handed_q;
    drop_unread  = 1'b0;
    drop_block   = 1'b0;
    rep_inc      = 1'b0;
    done_acc     = (state_q == ST_WRITING) && wr_frame_done;
    cand         = wrap_add(wr_bufn_q, 8'd1);

    case (state_q)
      ST_IDLE:    state_d = wr_frame_start ? ST_WRITING : ST_IDLE;
      ST_WRITING: state_d = wr_frame_done ? ST_IDLE : ST_WRITING;
      default:    state_d = ST_IDLE;
    endcase

    if (done_acc) begin
      last_done_d  = wr_bufn_q;
      done_valid_d = 1'b1;
      rd_valid_d   = 1'b1;
    end else begin
      last_done_d  = last_done_q;
      done_valid_d = done_valid_q;
      rd_valid_d   = rd_valid_q;
    end

    if (MODE == 0) begin
      wr_bufn_d = done_acc ? cand : wr_bufn_q;
      rd_bufn_d = rd_frame_start ? wrap_add(wr_bufn_d, RD_LAG) : rd_bufn_q;
    end else begin
      // handed_q: the current last_done has already been given to the reader.
      if (rd_frame_start && done_acc) begin
        rd_bufn_d = wr_bufn_q;
        handed_d  = 1'b1;
      end else if (rd_frame_start && done_valid_q) begin
        rd_bufn_d = last_done_q;
        handed_d  = 1'b1;
        rep_inc   = handed_q;
      end else if (rd_frame_start) begin
        rd_bufn_d = rd_bufn_q;
        rep_inc   = 1'b1;
      end else if (done_acc) begin
        handed_d  = 1'b0;
      end else begin
        handed_d  = handed_q;
      end

      drop_unread = done_acc && done_valid_q && !handed_q;

      // Collision check uses rd_bufn_d so a coincident read is already accounted for.
      if (!done_acc) begin
        wr_bufn_d = wr_bufn_q;
      end else if (cand != rd_bufn_d) begin
        wr_bufn_d = cand;
      end else if (BUF_LENTH >= 3) begin
        wr_bufn_d = wrap_add(wr_bufn_q, 8'd2);
      end else begin
        wr_bufn_d  = wr_bufn_q;
        drop_block = 1'b1;
      end
    end

    drop_cnt_d = sat_add(drop_cnt_q, {1'b0, drop_unread} + {1'b0, drop_block});
    rep_cnt_d  = sat_add(rep_cnt_q, {1'b0, rep_inc});
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      wr_bufn_q    <= 8'd0;
      rd_bufn_q    <= RD_RST;
      last_done_q  <= 8'd0;
      done_valid_q <= 1'b0;
      rd_valid_q   <= 1'b0;
      handed_q     <= 1'b0;
      drop_cnt_q   <= 16'd0;
      rep_cnt_q    <= 16'd0;
    end else begin
      state_q      <= state_d;
      wr_bufn_q    <= wr_bufn_d;
      rd_bufn_q    <= rd_bufn_d;
      last_done_q  <= last_done_d;
      done_valid_q <= done_valid_d;
      rd_valid_q   <= rd_valid_d;
      handed_q     <= handed_d;
      drop_cnt_q   <= drop_cnt_d;
      rep_cnt_q    <= rep_cnt_d;
    end
  end

  assign wr_bufn  = wr_bufn_q;
  assign rd_bufn  = rd_bufn_q;
  assign rd_valid = rd_valid_q;
  assign drop_cnt = drop_cnt_q;
  assign rep_cnt  = rep_cnt_q;

endmodule
